// File: rtl/memory_cycle_stage.sv
// Memory stage of the pipeline: drives a variable-latency data memory over req/ack,
// stalls upstream while an access is pending and owns the MEM/WB register.
module memory_cycle_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        BusErr
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          regwrite_q, regwrite_d;
  logic [1:0]    resultsrc_q, resultsrc_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   pc4_q, pc4_d;
  logic [31:0]   alu_q, alu_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          buserr_q, buserr_d;
  logic          stall_s;
  logic          mem_op_s;
  logic          timeout_s;

  assign mem_op_s  = MemWriteM | (ResultSrcM == 2'b01);
  assign timeout_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state, memory request and MEM/WB register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buserr_d    = buserr_q;
    stall_s     = 1'b0;
    // W fields default to a bubble
    regwrite_d  = 1'b0;
    resultsrc_d = 2'b00;
    rd_d        = 5'd0;
    pc4_d       = 32'd0;
    alu_d       = 32'd0;
    rdata_d     = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          stall_s = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALU_ResultM[31:2], 2'b00};
          wdata_d = WriteDataM;
          cnt_d   = {CW{1'b0}};
          state_d = S_BUSY;
        end else begin
          regwrite_d  = RegWriteM;
          resultsrc_d = ResultSrcM;
          rd_d        = RD_M;
          pc4_d       = PCPlus4M;
          alu_d       = ALU_ResultM;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          regwrite_d  = RegWriteM;
          resultsrc_d = ResultSrcM;
          rd_d        = RD_M;
          pc4_d       = PCPlus4M;
          alu_d       = ALU_ResultM;
          rdata_d     = we_q ? 32'd0 : dmem_rdata;
          req_d       = 1'b0;
          cnt_d       = {CW{1'b0}};
          state_d     = S_IDLE;
        end else if (timeout_s) begin
          // Abandon the access: retire the instruction without a register write
          resultsrc_d = ResultSrcM;
          rd_d        = RD_M;
          pc4_d       = PCPlus4M;
          alu_d       = ALU_ResultM;
          buserr_d    = 1'b1;
          req_d       = 1'b0;
          cnt_d       = {CW{1'b0}};
          state_d     = S_IDLE;
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = {CW{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      rd_q        <= 5'd0;
      pc4_q       <= 32'd0;
      alu_q       <= 32'd0;
      rdata_q     <= 32'd0;
      buserr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      pc4_q       <= pc4_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      buserr_q    <= buserr_d;
    end
  end

  // Stall is held low while reset is asserted so upstream never freezes during reset
  assign StallM      = stall_s & rst;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign RegWriteW   = regwrite_q;
  assign ResultSrcW  = resultsrc_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pc4_q;
  assign ALU_ResultW = alu_q;
  assign ReadDataW   = rdata_q;
  assign BusErr      = buserr_q;

endmodule

// File: tb/tb_memory_cycle_stage.sv
// Scoreboard bench for memory_cycle_stage: stimulus pushes the expected MEM/WB result of
// each instruction, a negedge monitor pops it when the stage retires an instruction.
module tb_memory_cycle_stage;
  localparam int TMO = 16;

  logic        clk, rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, StallM, RegWriteW, BusErr;
  logic [31:0] dmem_addr, dmem_wdata, PCPlus4W, ALU_ResultW, ReadDataW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;

  memory_cycle_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .BusErr(BusErr)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        be;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic pend_rst = 1'b1;
  logic pend_done = 1'b0;
  logic exp_be = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares MEM/WB contents against the scoreboard every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      rec_t r;
      if (pend_rst) begin
        exp_be = 1'b0;
        r = '{1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0};
      end else if (pend_done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_underflow: got retire expected none at %0t", $time);
          r = '{1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        end else begin
          r = q.pop_front();
        end
        exp_be = exp_be | r.be;
      end else begin
        r = '{1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0};
      end
      if (!pend_rst && pend_done || pend_rst || !pend_done) begin
        chk("w_ctl", {24'd0, RegWriteW, ResultSrcW, RD_W}, {24'd0, r.rw, r.rs, r.rd});
        chk("w_pc4", PCPlus4W, r.pc);
        chk("w_alu", ALU_ResultW, r.alu);
        chk("w_rdata", ReadDataW, r.rdata);
      end
      chk("buserr", 32'(BusErr), 32'(exp_be));
      pend_rst  = !rst;
      pend_done = rst && !StallM;
    end
  end

  // One instruction through the stage; called just after a rising edge.
  // delay = BUSY cycles without ack before ack; >= TMO means no ack (timeout).
  task automatic run_instr(input logic rw, input logic mw, input logic [1:0] rs,
                           input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                           input logic [31:0] alu, input int delay, input logic [31:0] rdata);
    logic mem;
    int   stalls;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu; dmem_ack = 1'b0;
    mem = mw || (rs == 2'b01);
    @(negedge clk);
    chk("req_low_at_issue", 32'(dmem_req), 32'd0);
    chk("stall_issue", 32'(StallM), 32'(mem));
    if (!mem) begin
      q.push_back('{rw, rs, rd, pc, alu, 32'd0, 1'b0});
      @(posedge clk); #1;
      return;
    end
    stalls = 1;
    for (int i = 0; i < TMO; i++) begin
      @(posedge clk); #1;
      if (i == delay) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end else begin
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      chk("dmem_req", 32'(dmem_req), 32'd1);
      chk("dmem_we", 32'(dmem_we), 32'(mw));
      chk("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
      chk("dmem_wdata", dmem_wdata, wd);
      if (i == delay) begin
        chk("stall_ack", 32'(StallM), 32'd0);
        q.push_back('{rw, rs, rd, pc, alu, mw ? 32'd0 : rdata, 1'b0});
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        break;
      end else if (i == TMO - 1) begin
        chk("stall_timeout", 32'(StallM), 32'd0);
        q.push_back('{1'b0, rs, rd, pc, alu, 32'd0, 1'b1});
        @(posedge clk); #1;
        break;
      end else begin
        chk("stall_busy", 32'(StallM), 32'd1);
        stalls++;
      end
    end
    chk("stall_cycles", 32'(stalls), 32'(1 + ((delay < TMO - 1) ? delay : TMO - 1)));
  endtask

  initial begin
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      RegWriteM = 1'($urandom); MemWriteM = 1'($urandom); ResultSrcM = 2'($urandom);
      RD_M = 5'($urandom); PCPlus4M = $urandom; WriteDataM = $urandom;
      ALU_ResultM = $urandom; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_w_ctl", {24'd0, RegWriteW, ResultSrcW, RD_W}, 32'd0);
    chk("rst_pc4", PCPlus4W, 32'd0);
    chk("rst_alu", ALU_ResultW, 32'd0);
    chk("rst_rdata", ReadDataW, 32'd0);
    chk("rst_buserr", 32'(BusErr), 32'd0);
    dmem_ack = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU op, load with 3 wait cycles, store acked at once, ack on the timeout cycle
    run_instr(1'b1, 1'b0, 2'b00, 5'd5, 32'h4, 32'h0, 32'h1234, 0, 32'h0);
    run_instr(1'b1, 1'b0, 2'b01, 5'd7, 32'h8, 32'h0, 32'h103, 3, 32'hCAFEF00D);
    run_instr(1'b0, 1'b1, 2'b00, 5'd0, 32'hC, 32'hA5A5A5A5, 32'h40, 0, 32'h0);
    run_instr(1'b1, 1'b0, 2'b01, 5'd9, 32'h10, 32'h0, 32'h202, TMO - 1, 32'h600DF00D);
    // Timeout, then a normal ALU op with BusErr sticky
    run_instr(1'b1, 1'b0, 2'b01, 5'd3, 32'h14, 32'h0, 32'h300, 100, 32'h0);
    run_instr(1'b1, 1'b0, 2'b10, 5'd4, 32'h18, 32'h0, 32'h55, 0, 32'h0);

    // Reset mid-BUSY, then a late ack while IDLE must be ignored
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RD_M = 5'd11;
    PCPlus4M = 32'h1C; WriteDataM = 32'h0; ALU_ResultM = 32'h500;
    @(negedge clk);
    chk("mid_stall_issue", 32'(StallM), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_req_busy", 32'(dmem_req), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; RD_M = 5'd12;
    PCPlus4M = 32'h20; ALU_ResultM = 32'h77; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD;
    @(negedge clk);
    chk("mid_req_dropped", 32'(dmem_req), 32'd0);
    chk("mid_stall_low", 32'(StallM), 32'd0);
    q.push_back('{1'b1, 2'b00, 5'd12, 32'h20, 32'h77, 32'd0, 1'b0});
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int          kind, dly;
      logic [1:0]  rs;
      kind = $urandom_range(0, 2);
      rs = 2'($urandom_range(0, 2));
      if (rs == 2'b01) rs = 2'b11;
      dly = ($urandom_range(0, 9) == 0) ? TMO + 4 : $urandom_range(0, 4);
      case (kind)
        0: run_instr(1'($urandom), 1'b0, rs, 5'($urandom), $urandom, $urandom, $urandom, dly, $urandom);
        1: run_instr(1'($urandom), 1'b0, 2'b01, 5'($urandom), $urandom, $urandom, $urandom, dly, $urandom);
        default: run_instr(1'($urandom), 1'b1, rs, 5'($urandom), $urandom, $urandom, $urandom, dly, $urandom);
      endcase
    end

    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
